block_drop_ctrl: RTL and testbench
==================================

BLOCK_DROP_CTRL -- requirements
Module: block_drop_ctrl

Interface
- REQ-001: Parameter FALL_STEP, default 2, pixels moved per frame_tick; legal range 1-63.
- REQ-002: Parameter FLOOR_Y, default 479, lowest Y position; a block reaching it has landed (missed).
- REQ-003: Parameter SPAWN_Y, default 0, Y position at spawn and respawn.
- REQ-004: Parameter MAX_MISS, default 3, miss count that ends the game; legal range 1-7.
- REQ-005: Clk, input, 1, system clock; all state changes on posedge Clk.
- REQ-006: Reset, input, 1, asynchronous, active-high.
- REQ-007: frame_tick, input, 1, single-cycle pulse once per video frame.
- REQ-008: block_ready[0:4], input, 5x1, per-lane enable from the block release sequencer; a lane, once high, stays high until Reset.
- REQ-009: catch[0:4], input, 5x1, per-lane player-hit strobe; sampled every cycle.
- REQ-010: block_y[0:4], output, 5x10, current Y position per lane.
- REQ-011: block_active[0:4], output, 5x1, lane is falling and must be drawn.
- REQ-012: score, output, 8, caught-block count.
- REQ-013: miss_count, output, 3, landed-block count.
- REQ-014: game_over, output, 1, sticky end-of-game flag.

Function
- REQ-015: Each lane has an independent 3-state FSM with states IDLE, FALL and RESPAWN.
- REQ-016: IDLE->FALL on the cycle block_ready[i] is high (level, not edge), with block_y[i] loaded to SPAWN_Y.
- REQ-017: In FALL, on each frame_tick, block_y[i] advances by FALL_STEP, with the sum computed in 11 bits to avoid wrap.
- REQ-018: In FALL, if block_y[i]+FALL_STEP >= FLOOR_Y on a frame_tick, block_y[i] clamps to FLOOR_Y, the lane moves to RESPAWN and a miss counts for that lane.
- REQ-019: In FALL, catch[i]=1 moves the lane to RESPAWN, loads block_y[i] to SPAWN_Y and counts a catch for that lane.
- REQ-020: When catch[i] and a landing frame_tick occur in the same cycle, the catch wins: score increments and miss_count does not.
- REQ-021: RESPAWN->FALL on the next frame_tick, with block_y[i] = SPAWN_Y; no Y advance occurs on that tick.
- REQ-022: block_active[i] is 1 only in FALL, and is registered.
- REQ-023: catch[i] is ignored in IDLE and RESPAWN.
- REQ-024: Per cycle, score += (number of lanes caught), saturating at 255.
- REQ-025: Per cycle, miss_count += (number of lanes landed), saturating at 7.
- REQ-026: game_over is set on the cycle after miss_count >= MAX_MISS, and holds until Reset.
- REQ-027: While game_over=1, all lanes are forced to IDLE, block_active = 0, block_y holds, score and miss_count freeze, and catch and frame_tick are ignored.
- REQ-028: Latency from frame_tick or catch to updated outputs is 1 clock cycle.

Reset
- REQ-029: Reset=1 immediately drives all lanes to IDLE, block_y = SPAWN_Y, block_active = 0, score = 0, miss_count = 0 and game_over = 0, including mid-fall.
- REQ-030: After Reset deasserts, lanes whose block_ready is high re-enter FALL on the first clock edge.

Verification
- REQ-031: Scenario 1: block_ready[0]=1 with default parameters, frame_tick every 10 cycles -> block_y[0] = 0,2,4,...; after 239 ticks y=478; the 240th tick gives y=479, active=0, miss_count=1.
- REQ-032: Scenario 2: lane 1 falling at y=100, catch[1] pulse -> next cycle score=1, block_y[1]=0, active=0; the next frame_tick gives active=1 and y=0.
- REQ-033: Scenario 3: lane 2 at y=478, catch[2] and frame_tick in the same cycle -> score+1, miss_count unchanged.
- REQ-034: Scenario 4: lanes 0-4 all land on the same frame_tick with MAX_MISS=3 -> miss_count=5, game_over=1 one cycle later, all active=0, and further catch pulses do not change score.
- REQ-035: Scenario 5: with score=255, a catch -> score stays 255; with miss_count=7 and MAX_MISS=7, game_over=1.
- REQ-036: Scenario 6: Reset pulsed mid-fall (lane 3 at y=200, score=4) -> asynchronously y=0, score=0, active=0; after release, lane 3 resumes FALL from y=0.

Source files
------------

// File: rtl/block_drop_ctrl_if.sv
// Bus between the release sequencer / player input and the falling-block lane controller.
interface block_drop_ctrl_if;
  localparam int unsigned LANES = 5;
  localparam int unsigned YW    = 10;
  localparam int unsigned SW    = 8;
  localparam int unsigned MW    = 3;

  logic                      frame_tick;
  logic [LANES-1:0]          block_ready;
  logic [LANES-1:0]          catch;
  logic [LANES-1:0][YW-1:0]  block_y;
  logic [LANES-1:0]          block_active;
  logic [SW-1:0]             score;
  logic [MW-1:0]             miss_count;
  logic                      game_over;

  modport master (
    output frame_tick, block_ready, catch,
    input  block_y, block_active, score, miss_count, game_over
  );

  modport slave (
    input  frame_tick, block_ready, catch,
    output block_y, block_active, score, miss_count, game_over
  );
endinterface

// File: rtl/block_drop_ctrl.sv
// Five independent falling-block lanes with catch/miss scoring and a sticky game-over.
module block_drop_ctrl #(
  parameter int unsigned FALL_STEP = 2,
  parameter int unsigned FLOOR_Y   = 479,
  parameter int unsigned SPAWN_Y   = 0,
  parameter int unsigned MAX_MISS  = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  block_drop_ctrl_if.slave bus
);
  localparam int unsigned LANES = 5;
  localparam int unsigned YW    = 10;
  localparam int unsigned YSW   = YW + 1;
  localparam int unsigned SW    = 8;
  localparam int unsigned SSW   = SW + 1;
  localparam int unsigned MW    = 3;
  localparam int unsigned MSW   = MW + 1;
  localparam int unsigned CW    = 3;

  localparam logic [YW-1:0]  SPAWN   = YW'(SPAWN_Y);
  localparam logic [YW-1:0]  FLOOR   = YW'(FLOOR_Y);
  localparam logic [YSW-1:0] FLOOR_W = YSW'(FLOOR_Y);
  localparam logic [YSW-1:0] STEP_W  = YSW'(FALL_STEP);
  localparam logic [MW-1:0]  MISS_LIM = MW'(MAX_MISS);

  typedef enum logic [1:0] {S_IDLE, S_FALL, S_RESPAWN} lane_state_e;

  lane_state_e               state_q [LANES];
  lane_state_e               state_d [LANES];
  logic [LANES-1:0][YW-1:0]  y_q, y_d;
  logic [LANES-1:0][YSW-1:0] sum_c;
  logic [LANES-1:0]          land_c;
  logic [LANES-1:0]          active_q, active_d;
  logic [LANES-1:0]          caught_c, landed_c;
  logic [SW-1:0]             score_q, score_d;
  logic [SSW-1:0]            score_sum_c;
  logic [MW-1:0]             miss_q, miss_d;
  logic [MSW-1:0]            miss_sum_c;
  logic                      game_over_q;
  logic                      halt_c;

  function automatic logic [CW-1:0] ones(input logic [LANES-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(LANES); i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Once the miss limit is reached the lanes stop on the same edge that raises game_over.
  assign halt_c = game_over_q | (miss_q >= MISS_LIM);

  // 11-bit advance so a step near the top of the Y range cannot wrap past the floor.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      sum_c[i]  = YSW'(y_q[i]) + STEP_W;
      land_c[i] = bus.frame_tick & (sum_c[i] >= FLOOR_W);
    end
  end

  // Lane state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(LANES); i++) state_q[i] <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lane next-state logic; a catch takes priority over a landing tick.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      state_d[i] = state_q[i];
      if (halt_c) begin
        state_d[i] = S_IDLE;
      end else begin
        case (state_q[i])
          S_IDLE:    if (bus.block_ready[i])            state_d[i] = S_FALL;
          S_FALL:    if (bus.catch[i] || land_c[i])     state_d[i] = S_RESPAWN;
          S_RESPAWN: if (bus.frame_tick)                state_d[i] = S_FALL;
          default:                                      state_d[i] = S_IDLE;
        endcase
      end
    end
  end

  // Lane outputs: next Y, catch/land events and next active flag.
  always_comb begin
    y_d      = y_q;
    caught_c = '0;
    landed_c = '0;
    active_d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (!halt_c) begin
        case (state_q[i])
          S_IDLE: if (bus.block_ready[i]) y_d[i] = SPAWN;
          S_FALL: begin
            if (bus.catch[i]) begin
              y_d[i]      = SPAWN;
              caught_c[i] = 1'b1;
            end else if (land_c[i]) begin
              y_d[i]      = FLOOR;
              landed_c[i] = 1'b1;
            end else if (bus.frame_tick) begin
              y_d[i] = sum_c[i][YW-1:0];
            end
          end
          S_RESPAWN: if (bus.frame_tick) y_d[i] = SPAWN;
          default: ;
        endcase
      end
      active_d[i] = (state_d[i] == S_FALL);
    end
  end

  // Saturating score and miss counters.
  always_comb begin
    score_sum_c = SSW'(score_q) + SSW'(ones(caught_c));
    miss_sum_c  = MSW'(miss_q) + MSW'(ones(landed_c));
    score_d     = score_sum_c[SW] ? '1 : score_sum_c[SW-1:0];
    miss_d      = miss_sum_c[MW]  ? '1 : miss_sum_c[MW-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      y_q         <= {LANES{SPAWN}};
      active_q    <= '0;
      score_q     <= '0;
      miss_q      <= '0;
      game_over_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      active_q    <= active_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
      game_over_q <= halt_c;
    end
  end

  assign bus.block_y      = y_q;
  assign bus.block_active = active_q;
  assign bus.score        = score_q;
  assign bus.miss_count   = miss_q;
  assign bus.game_over    = game_over_q;
endmodule

// File: tb/tb_block_drop_ctrl.sv
// Bench for block_drop_ctrl: two parameterisations driven in lockstep against a behavioural model.
module tb_block_drop_ctrl;
  localparam int A_STEP = 2,  A_FLOOR = 479,  A_SPAWN = 0, A_MAX = 3;
  localparam int B_STEP = 63, B_FLOOR = 1020, B_SPAWN = 7, B_MAX = 7;

  typedef struct packed {
    logic [4:0][9:0] y;
    logic [4:0]      fall;
    logic [4:0]      resp;
    logic [7:0]      score;
    logic [2:0]      miss;
    logic            go;
  } model_t;

  logic   Clk = 1'b0;
  logic   Reset;
  int     n_checks = 0;
  int     n_fail = 0;
  model_t ma, mb;
  logic [4:0] rc, rr;

  always #5 Clk = ~Clk;

  block_drop_ctrl_if bus_a ();
  block_drop_ctrl_if bus_b ();

  block_drop_ctrl #(.FALL_STEP(A_STEP), .FLOOR_Y(A_FLOOR), .SPAWN_Y(A_SPAWN), .MAX_MISS(A_MAX))
    dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a));
  block_drop_ctrl #(.FALL_STEP(B_STEP), .FLOOR_Y(B_FLOOR), .SPAWN_Y(B_SPAWN), .MAX_MISS(B_MAX))
    dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b));

  function automatic model_t model_reset(input int spawn);
    model_t n;
    for (int i = 0; i < 5; i++) n.y[i] = 10'(spawn);
    n.fall = '0; n.resp = '0; n.score = '0; n.miss = '0; n.go = 1'b0;
    return n;
  endfunction

  // One clock of the game rules, written from the behavioural description.
  function automatic model_t model_step(input model_t m, input logic [4:0] rdy, input logic [4:0] cat,
                                        input logic tick, input int step, input int floor,
                                        input int spawn, input int maxm);
    model_t n;
    int caught, landed, s, ms;
    n = m; caught = 0; landed = 0;
    if (m.go || int'(m.miss) >= maxm) begin
      n.fall = '0; n.resp = '0; n.go = 1'b1;
      return n;
    end
    for (int i = 0; i < 5; i++) begin
      if (m.fall[i]) begin
        if (cat[i]) begin
          n.fall[i] = 1'b0; n.resp[i] = 1'b1; n.y[i] = 10'(spawn); caught++;
        end else if (tick) begin
          if (int'(m.y[i]) + step >= floor) begin
            n.fall[i] = 1'b0; n.resp[i] = 1'b1; n.y[i] = 10'(floor); landed++;
          end else begin
            n.y[i] = 10'(int'(m.y[i]) + step);
          end
        end
      end else if (m.resp[i]) begin
        if (tick) begin n.resp[i] = 1'b0; n.fall[i] = 1'b1; n.y[i] = 10'(spawn); end
      end else if (rdy[i]) begin
        n.fall[i] = 1'b1; n.y[i] = 10'(spawn);
      end
    end
    s  = int'(m.score) + caught;
    ms = int'(m.miss) + landed;
    n.score = 8'((s > 255) ? 255 : s);
    n.miss  = 3'((ms > 7) ? 7 : ms);
    return n;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ma = model_reset(A_SPAWN);
      mb = model_reset(B_SPAWN);
    end else begin
      ma = model_step(ma, bus_a.block_ready, bus_a.catch, bus_a.frame_tick, A_STEP, A_FLOOR, A_SPAWN, A_MAX);
      mb = model_step(mb, bus_b.block_ready, bus_b.catch, bus_b.frame_tick, B_STEP, B_FLOOR, B_SPAWN, B_MAX);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_env(input string tag, input model_t m, input logic [4:0][9:0] y,
                         input logic [4:0] act, input logic [7:0] sc, input logic [2:0] mc,
                         input logic go);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s.block_y[%0d]", tag, i), 32'(y[i]), 32'(m.y[i]));
      check($sformatf("%s.block_active[%0d]", tag, i), 32'(act[i]), 32'(m.fall[i]));
    end
    check({tag, ".score"}, 32'(sc), 32'(m.score));
    check({tag, ".miss_count"}, 32'(mc), 32'(m.miss));
    check({tag, ".game_over"}, 32'(go), 32'(m.go));
  endtask

  // Every cycle, both DUTs against the model, away from the active edge.
  always @(negedge Clk) begin
    cmp_env("A", ma, bus_a.block_y, bus_a.block_active, bus_a.score, bus_a.miss_count, bus_a.game_over);
    cmp_env("B", mb, bus_b.block_y, bus_b.block_active, bus_b.score, bus_b.miss_count, bus_b.game_over);
  end

  task automatic set_inputs(input logic t, input logic [4:0] r, input logic [4:0] c);
    bus_a.frame_tick = t; bus_a.block_ready = r; bus_a.catch = c;
    bus_b.frame_tick = t; bus_b.block_ready = r; bus_b.catch = c;
  endtask

  // One clock with the given inputs; returns just after the edge that sampled them.
  task automatic drive(input logic t, input logic [4:0] r, input logic [4:0] c);
    @(negedge Clk); #1;
    set_inputs(t, r, c);
    @(posedge Clk); #2;
  endtask

  task automatic ticks(input int n, input logic [4:0] r, input int gap);
    repeat (n) begin
      drive(1'b1, r, 5'b0);
      repeat (gap) drive(1'b0, r, 5'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk); #1;
    Reset = 1'b1;
    set_inputs(1'b0, 5'b0, 5'b0);
    @(posedge Clk); @(posedge Clk);
    @(negedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #2;
  endtask

  initial begin
    Reset = 1'b1;
    set_inputs(1'b0, 5'b0, 5'b0);
    repeat (2) @(posedge Clk);
    #2;
    check("reset A.block_y[0]", 32'(bus_a.block_y[0]), 32'd0);
    check("reset B.block_y[4]", 32'(bus_b.block_y[4]), 32'd7);
    check("reset A.block_active", 32'(bus_a.block_active), 32'd0);
    check("reset A.score", 32'(bus_a.score), 32'd0);
    check("reset A.game_over", 32'(bus_a.game_over), 32'd0);
    @(negedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #2;

    // Lane 0 falls to the floor with a tick every 10 cycles.
    drive(1'b0, 5'b00001, 5'b0);
    check("s1 enter active", 32'(bus_a.block_active[0]), 32'd1);
    check("s1 enter y", 32'(bus_a.block_y[0]), 32'd0);
    ticks(1, 5'b00001, 9);
    check("s1 first tick y", 32'(bus_a.block_y[0]), 32'd2);
    ticks(238, 5'b00001, 9);
    check("s1 y after 239", 32'(bus_a.block_y[0]), 32'd478);
    check("s1 miss before land", 32'(bus_a.miss_count), 32'd0);
    drive(1'b1, 5'b00001, 5'b0);
    check("s1 land y", 32'(bus_a.block_y[0]), 32'd479);
    check("s1 land active", 32'(bus_a.block_active[0]), 32'd0);
    check("s1 land miss", 32'(bus_a.miss_count), 32'd1);
    check("s1 B miss sat", 32'(bus_b.miss_count), 32'd7);
    check("s1 B game_over", 32'(bus_b.game_over), 32'd1);
    check("s1 B y clamp no wrap", 32'(bus_b.block_y[0]), 32'd1020);

    // Catch at y=100, catch ignored in respawn, resume on next tick.
    do_reset();
    drive(1'b0, 5'b00010, 5'b0);
    ticks(50, 5'b00010, 0);
    check("s2 y100", 32'(bus_a.block_y[1]), 32'd100);
    drive(1'b0, 5'b00010, 5'b00010);
    check("s2 catch score", 32'(bus_a.score), 32'd1);
    check("s2 catch y", 32'(bus_a.block_y[1]), 32'd0);
    check("s2 catch active", 32'(bus_a.block_active[1]), 32'd0);
    drive(1'b0, 5'b00010, 5'b00010);
    check("s2 respawn catch ignored", 32'(bus_a.score), 32'd1);
    drive(1'b1, 5'b00010, 5'b0);
    check("s2 respawn active", 32'(bus_a.block_active[1]), 32'd1);
    check("s2 respawn y", 32'(bus_a.block_y[1]), 32'd0);
    drive(1'b1, 5'b00010, 5'b0);
    check("s2 advance y", 32'(bus_a.block_y[1]), 32'd2);

    // Catch and landing tick in the same cycle: catch wins.
    do_reset();
    drive(1'b0, 5'b00100, 5'b0);
    ticks(239, 5'b00100, 0);
    check("s3 y478", 32'(bus_a.block_y[2]), 32'd478);
    drive(1'b1, 5'b00100, 5'b00100);
    check("s3 score", 32'(bus_a.score), 32'd1);
    check("s3 miss", 32'(bus_a.miss_count), 32'd0);
    check("s3 y", 32'(bus_a.block_y[2]), 32'd0);

    // All five lanes land together.
    do_reset();
    drive(1'b0, 5'b11111, 5'b0);
    ticks(239, 5'b11111, 0);
    for (int i = 0; i < 5; i++) check($sformatf("s4 y478 lane%0d", i), 32'(bus_a.block_y[i]), 32'd478);
    drive(1'b1, 5'b11111, 5'b0);
    check("s4 miss5", 32'(bus_a.miss_count), 32'd5);
    check("s4 go not yet", 32'(bus_a.game_over), 32'd0);
    check("s4 active off", 32'(bus_a.block_active), 32'd0);
    drive(1'b0, 5'b11111, 5'b0);
    check("s4 go set", 32'(bus_a.game_over), 32'd1);
    repeat (3) drive(1'b1, 5'b11111, 5'b11111);
    check("s4 frozen score", 32'(bus_a.score), 32'd0);
    check("s4 frozen miss", 32'(bus_a.miss_count), 32'd5);
    check("s4 frozen active", 32'(bus_a.block_active), 32'd0);
    check("s4 frozen y", 32'(bus_a.block_y[0]), 32'd479);

    // Exactly MAX_MISS misses.
    do_reset();
    drive(1'b0, 5'b00111, 5'b0);
    ticks(240, 5'b00111, 0);
    check("s4b miss3", 32'(bus_a.miss_count), 32'd3);
    check("s4b go not yet", 32'(bus_a.game_over), 32'd0);
    drive(1'b0, 5'b00111, 5'b0);
    check("s4b go set", 32'(bus_a.game_over), 32'd1);

    // Random catches on all lanes drive the score into saturation.
    do_reset();
    repeat (3000) begin
      for (int k = 0; k < 5; k++) rc[k] = ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 2) == 0, 5'b11111, rc);
    end
    check("s5 score sat", 32'(bus_a.score), 32'd255);

    // Sparse catches and lanes released at random: misses and game over.
    repeat (3) begin
      do_reset();
      rr = '0;
      repeat (500) begin
        for (int k = 0; k < 5; k++) begin
          if ($urandom_range(0, 30) == 0) rr[k] = 1'b1;
          rc[k] = ($urandom_range(0, 39) == 0);
        end
        drive($urandom_range(0, 1) == 0, rr, rc);
      end
    end

    // Asynchronous reset mid-fall.
    do_reset();
    drive(1'b0, 5'b01000, 5'b0);
    repeat (4) begin
      drive(1'b0, 5'b01000, 5'b01000);
      drive(1'b1, 5'b01000, 5'b0);
    end
    ticks(100, 5'b01000, 0);
    drive(1'b0, 5'b01000, 5'b0);
    check("s6 y200", 32'(bus_a.block_y[3]), 32'd200);
    check("s6 score4", 32'(bus_a.score), 32'd4);
    @(negedge Clk); #1;
    Reset = 1'b1;
    #1;
    check("s6 async y", 32'(bus_a.block_y[3]), 32'd0);
    check("s6 async score", 32'(bus_a.score), 32'd0);
    check("s6 async active", 32'(bus_a.block_active[3]), 32'd0);
    @(posedge Clk);
    @(negedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #2;
    check("s6 resume active", 32'(bus_a.block_active[3]), 32'd1);
    check("s6 resume y", 32'(bus_a.block_y[3]), 32'd0);
    drive(1'b1, 5'b01000, 5'b0);
    check("s6 resume advance", 32'(bus_a.block_y[3]), 32'd2);
    drive(1'b0, 5'b01000, 5'b0);

    @(negedge Clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
